// File: rtl/pl_pkg.sv
// ============================================================================
//  Module  : pl_pkg
//  Brief   : Shared types and constants for elastic pipeline-stage registers.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package pl_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } pl_stage_state_e;

    localparam logic [31:0] PL_NOP_INSTR = 32'h0000_0013;

    localparam int PL_XLEN          = 32;
    // {instr, pc, pc_plus4}
    localparam int PL_IF_ID_DATA_W  = 3 * PL_XLEN;
    localparam int PL_ID_EX_DATA_W  = 5 * PL_XLEN;
    localparam int PL_CTRL_W        = 20;
    localparam int PL_PERF_CNT_W    = 32;

endpackage

`default_nettype wire

// File: rtl/pl_perf_cnt.sv
// ============================================================================
//  Module  : pl_perf_cnt
//  Brief   : Single saturating event counter with synchronous clear.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module pl_perf_cnt
    import pl_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_inc,
    input  logic                     i_clr,
    output logic [PL_PERF_CNT_W-1:0] o_cnt
);

    logic [PL_PERF_CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset || i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != {PL_PERF_CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;

endmodule

`default_nettype wire

// File: rtl/pl_stage_elastic.sv
// ============================================================================
//  Module  : pl_stage_elastic
//  Brief   : Elastic pipeline-stage register, 2-entry skid, stall and flush.
//            Optional perf counters when PL_STAGE_PERF_EN is defined.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module pl_stage_elastic
    import pl_pkg::*;
#(
    parameter int                DATA_W   = PL_IF_ID_DATA_W,
    parameter int                CTRL_W   = PL_CTRL_W,
    parameter logic [DATA_W-1:0] NOP_DATA = DATA_W'(PL_NOP_INSTR)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              stall,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl
`ifdef PL_STAGE_PERF_EN
    ,
    output logic [31:0]       perf_stall_cnt,
    output logic [31:0]       perf_flush_cnt,
    output logic [31:0]       perf_bubble_cnt
`endif
);

    pl_stage_state_e   r_state;
    pl_stage_state_e   w_state_nxt;
    logic              r_in_ready;
    logic [DATA_W-1:0] r_main_data;
    logic [CTRL_W-1:0] r_main_ctrl;
    logic [DATA_W-1:0] r_skid_data;
    logic [CTRL_W-1:0] r_skid_ctrl;

    logic w_in_xfer;
    logic w_out_xfer;
    logic w_out_valid;

    assign w_out_valid = (r_state != EMPTY);
    assign w_in_xfer   = in_valid & r_in_ready & ~stall & ~flush;
    assign w_out_xfer  = w_out_valid & out_ready & ~stall;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            EMPTY: if (w_in_xfer) w_state_nxt = ONE;
            ONE: begin
                if (w_in_xfer && !w_out_xfer)      w_state_nxt = FULL;
                else if (!w_in_xfer && w_out_xfer) w_state_nxt = EMPTY;
            end
            FULL:    if (w_out_xfer) w_state_nxt = ONE;
            default: w_state_nxt = EMPTY;
        endcase
        if (flush) w_state_nxt = EMPTY;
    end

    // in_ready is registered from the next state, so it already reads 0 in the first FULL cycle.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_state     <= EMPTY;
            r_in_ready  <= 1'b1;
            r_main_data <= NOP_DATA;
            r_main_ctrl <= '0;
            r_skid_data <= NOP_DATA;
            r_skid_ctrl <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= (w_state_nxt != FULL);

            if (w_in_xfer && ((r_state == EMPTY) || ((r_state == ONE) && w_out_xfer))) begin
                r_main_data <= in_data;
                r_main_ctrl <= in_ctrl;
            end else if ((r_state == FULL) && w_out_xfer) begin
                r_main_data <= r_skid_data;
                r_main_ctrl <= r_skid_ctrl;
            end else if ((r_state == ONE) && w_out_xfer) begin
                r_main_data <= NOP_DATA;
                r_main_ctrl <= '0;
            end

            if ((r_state == ONE) && w_in_xfer && !w_out_xfer) begin
                r_skid_data <= in_data;
                r_skid_ctrl <= in_ctrl;
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = w_out_valid;
    assign out_data  = w_out_valid ? r_main_data : NOP_DATA;
    assign out_ctrl  = w_out_valid ? r_main_ctrl : '0;

`ifdef PL_STAGE_PERF_EN
    pl_perf_cnt u_perf_stall (
        .clk   (clk),
        .reset (reset),
        .i_inc (stall),
        .i_clr (1'b0),
        .o_cnt (perf_stall_cnt)
    );

    pl_perf_cnt u_perf_flush (
        .clk   (clk),
        .reset (reset),
        .i_inc (flush),
        .i_clr (1'b0),
        .o_cnt (perf_flush_cnt)
    );

    pl_perf_cnt u_perf_bubble (
        .clk   (clk),
        .reset (reset),
        .i_inc (~w_out_valid & out_ready),
        .i_clr (1'b0),
        .o_cnt (perf_bubble_cnt)
    );
`endif

endmodule

`default_nettype wire

// File: tb/tb_pl_stage_elastic.sv
// ============================================================================
//  Module  : tb_pl_stage_elastic
//  Brief   : Directed self-checking bench with an in-order scoreboard.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pl_stage_elastic;

    localparam int DATA_W = 96;
    localparam int CTRL_W = 20;
    localparam logic [DATA_W-1:0] NOP = 96'h13;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [CTRL_W-1:0] in_ctrl;
    logic              stall;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;
`ifdef PL_STAGE_PERF_EN
    logic [31:0]       perf_stall_cnt;
    logic [31:0]       perf_flush_cnt;
    logic [31:0]       perf_bubble_cnt;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    logic [CTRL_W+DATA_W-1:0] sb_q[$];

    always #5 clk = ~clk;

    pl_stage_elastic dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ctrl   (in_ctrl),
        .stall     (stall),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ctrl  (out_ctrl)
`ifdef PL_STAGE_PERF_EN
        ,
        .perf_stall_cnt  (perf_stall_cnt),
        .perf_flush_cnt  (perf_flush_cnt),
        .perf_bubble_cnt (perf_bubble_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input int d, input logic ordy);
        in_valid  = v;
        in_data   = DATA_W'(d);
        in_ctrl   = CTRL_W'(d + 1);
        out_ready = ordy;
    endtask

    // Scoreboard: pop on a downstream transfer, then flush clears, then push accepted input.
    always @(negedge clk) begin
        if (reset) begin
            sb_q.delete();
        end else begin
            if (out_valid && out_ready && !stall) begin
                chk("sb_has_entry", 128'(sb_q.size() != 0), 128'd1);
                if (sb_q.size() != 0) begin
                    logic [CTRL_W+DATA_W-1:0] exp_e;
                    exp_e = sb_q.pop_front();
                    chk("sb_data", 128'(out_data), 128'(exp_e[DATA_W-1:0]));
                    chk("sb_ctrl", 128'(out_ctrl), 128'(exp_e[CTRL_W+DATA_W-1:DATA_W]));
                end
            end
            if (flush) sb_q.delete();
            else if (in_valid && in_ready && !stall) sb_q.push_back({in_ctrl, in_data});
        end
    end

    initial begin
        reset = 1'b1; stall = 1'b0; flush = 1'b0;
        drive(1'b0, 0, 1'b0);

        // Reset
        step(); step();
        reset = 1'b0;
        chk("rst_out_valid", 128'(out_valid), 128'd0);
        chk("rst_in_ready",  128'(in_ready),  128'd1);
        chk("rst_out_ctrl",  128'(out_ctrl),  128'd0);
        chk("rst_out_data",  128'(out_data),  128'(NOP));

        // Streaming: 1-cycle latency, no gaps
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, i, 1'b1);
            step();
            chk("strm_valid", 128'(out_valid), 128'd1);
            chk("strm_data",  128'(out_data),  128'(i));
            chk("strm_ready", 128'(in_ready),  128'd1);
        end
        drive(1'b0, 0, 1'b1);
        step();
        chk("strm_end_valid", 128'(out_valid), 128'd0);

        // Backpressure
        drive(1'b1, 100, 1'b0); step();
        chk("bp_ready_one", 128'(in_ready), 128'd1);
        drive(1'b1, 101, 1'b0); step();
        chk("bp_ready_full", 128'(in_ready), 128'd0);
        chk("bp_head_a",     128'(out_data), 128'd100);
        drive(1'b1, 102, 1'b0); step(); step();
        chk("bp_hold_ready", 128'(in_ready), 128'd0);
        chk("bp_hold_head",  128'(out_data), 128'd100);
        out_ready = 1'b1; step();
        chk("bp_drain_b",  128'(out_data), 128'd101);
        chk("bp_ready_ret", 128'(in_ready), 128'd1);
        step();
        chk("bp_drain_c", 128'(out_data), 128'd102);
        drive(1'b0, 0, 1'b1); step();
        chk("bp_empty", 128'(out_valid), 128'd0);

        // Stall while FULL
        drive(1'b1, 200, 1'b0); step();
        drive(1'b1, 201, 1'b0); step();
        chk("st_full", 128'(in_ready), 128'd0);
        stall = 1'b1;
        drive(1'b1, 299, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("st_valid", 128'(out_valid), 128'd1);
            chk("st_data",  128'(out_data),  128'd200);
            chk("st_ready", 128'(in_ready),  128'd0);
        end
        stall = 1'b0;
        drive(1'b0, 0, 1'b1); step();
        chk("st_rel_data", 128'(out_data), 128'd201);
        step();
        chk("st_rel_empty", 128'(out_valid), 128'd0);

        // Flush in FULL with live input
        drive(1'b1, 300, 1'b0); step();
        drive(1'b1, 301, 1'b0); step();
        drive(1'b1, 302, 1'b0);
        flush = 1'b1; step();
        flush = 1'b0;
        chk("fl_valid", 128'(out_valid), 128'd0);
        chk("fl_ctrl",  128'(out_ctrl),  128'd0);
        chk("fl_ready", 128'(in_ready),  128'd1);
        chk("fl_data",  128'(out_data),  128'(NOP));
        drive(1'b0, 0, 1'b1); step();
        chk("fl_no_ghost", 128'(out_valid), 128'd0);

        // Flush + stall together: flush wins
        drive(1'b1, 400, 1'b0); step();
        stall = 1'b1; flush = 1'b1;
        drive(1'b1, 401, 1'b1); step();
        stall = 1'b0; flush = 1'b0;
        chk("fs_valid", 128'(out_valid), 128'd0);
        chk("fs_ready", 128'(in_ready),  128'd1);

        // Flush while a downstream transfer completes
        drive(1'b1, 500, 1'b1); step();
        drive(1'b1, 501, 1'b1);
        flush = 1'b1; step();
        flush = 1'b0;
        chk("fx_valid", 128'(out_valid), 128'd0);

        // Reset mid-stream, then clean restart
        drive(1'b1, 600, 1'b0); step();
        drive(1'b1, 601, 1'b0); step();
        reset = 1'b1; step();
        reset = 1'b0;
        chk("rm_valid", 128'(out_valid), 128'd0);
        chk("rm_ready", 128'(in_ready),  128'd1);
        drive(1'b1, 700, 1'b1); step();
        chk("rm_restart", 128'(out_data), 128'd700);
        drive(1'b0, 0, 1'b1); step();

`ifdef PL_STAGE_PERF_EN
        reset = 1'b1; drive(1'b0, 0, 1'b0); step();
        reset = 1'b0;
        stall = 1'b1;
        for (int i = 0; i < 5; i++) step();
        stall = 1'b0;
        flush = 1'b1; step(); step();
        flush = 1'b0; step();
        chk("pf_stall", 128'(perf_stall_cnt), 128'd5);
        chk("pf_flush", 128'(perf_flush_cnt), 128'd2);
        dut.u_perf_stall.r_cnt = 32'hFFFF_FFFD;
        stall = 1'b1;
        for (int i = 0; i < 5; i++) step();
        stall = 1'b0;
        chk("pf_sat", 128'(perf_stall_cnt), 128'hFFFF_FFFF);
`endif

        step();
        chk("sb_drained", 128'(sb_q.size()), 128'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
